laser_peak_detect: RTL and testbench

LASER_PEAK_DETECT -- requirements
Module: laser_peak_detect

---
 rtl/laser_peak_detect.sv | 130 +++++++++++++
 tb/tb_laser_peak_detect.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_peak_detect.sv
// laser_peak_detect: finds the brightest pixel (value, column) of every video line.
// Latency: report strobe (peak_valid) one cycle after the h_rise that closes a line.
// Backpressure: none; one pixel per dv_in cycle is always consumed, report is a strobe.
module laser_peak_detect #(
  parameter int         IMG_WIDTH = 859,
  parameter logic [7:0] THRESHOLD = 8'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] fvh_in,
  input  logic       dv_in,
  input  logic [7:0] px_in,
  output logic [9:0] peak_col,
  output logic [9:0] peak_row,
  output logic [7:0] peak_val,
  output logic       peak_found,
  output logic       peak_valid
);

  localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] ROW_LAST = 10'd1023;
  // Column counter value after a line's first pixel (stays 0 for a 1-pixel-wide image)
  localparam logic [9:0] COL_AFTER_FIRST = (COL_LAST == 10'd0) ? 10'd0 : 10'd1;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    LINE,
    EMIT
  } state_t;

  state_t     state;
  logic [1:0] fvh_prev;
  logic       h_rise;
  logic       v_rise;
  logic [9:0] col;
  logic [9:0] row;
  logic [9:0] max_col;
  logic [7:0] max_px;
  logic [9:0] col_next;
  logic       take_px;
  logic       unused_field;

  // The field bit carries no information for peak finding; both fields are handled alike.
  assign unused_field = fvh_in[2];

  assign h_rise = fvh_in[0] & ~fvh_prev[0];
  assign v_rise = fvh_in[1] & ~fvh_prev[1];

  // Timing history for rising-edge detection of the vertical and horizontal flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fvh_prev <= 2'b00;
    end else begin
      fvh_prev <= fvh_in[1:0];
    end
  end

  // Saturating column advance and strict-greater test (keeps the first occurrence on ties)
  always_comb begin
    col_next = (col == COL_LAST) ? col : col + 10'd1;
    take_px  = dv_in && (px_in > max_px);
  end

  // Frame/line sequencing, per-line max accumulation and registered report outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_FRAME;
      col        <= 10'd0;
      row        <= 10'd0;
      max_px     <= 8'd0;
      max_col    <= 10'd0;
      peak_col   <= 10'd0;
      peak_row   <= 10'd0;
      peak_val   <= 8'd0;
      peak_found <= 1'b0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (v_rise) begin
        // New frame wins over everything: partial line is dropped without a report
        state   <= LINE;
        row     <= 10'd0;
        col     <= 10'd0;
        max_px  <= 8'd0;
        max_col <= 10'd0;
      end else begin
        case (state)
          WAIT_FRAME: begin
            state <= WAIT_FRAME;
          end
          LINE: begin
            if (h_rise) begin
              peak_col   <= max_col;
              peak_row   <= row;
              peak_val   <= max_px;
              peak_found <= (max_px >= THRESHOLD);
              peak_valid <= 1'b1;
              // A pixel on the h_rise cycle is column 0 of the next line
              max_px     <= dv_in ? px_in : 8'd0;
              max_col    <= 10'd0;
              col        <= dv_in ? COL_AFTER_FIRST : 10'd0;
              state      <= EMIT;
            end else if (dv_in) begin
              if (take_px) begin
                max_px  <= px_in;
                max_col <= col;
              end
              col <= col_next;
            end
          end
          EMIT: begin
            row <= (row == ROW_LAST) ? row : row + 10'd1;
            if (dv_in) begin
              if (take_px) begin
                max_px  <= px_in;
                max_col <= col;
              end
              col <= col_next;
            end
            state <= LINE;
          end
          default: begin
            state <= WAIT_FRAME;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_laser_peak_detect.sv
// tb_laser_peak_detect: random and directed line streams against a per-line reference model.
// Latency: model predicts outputs registered at each rising edge, sampled 1 time unit later.
// Backpressure: not applicable; stimulus is free-running one cycle per step.
module tb_laser_peak_detect;

  localparam int W  = 859;
  localparam int TH = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fvh_in;
  logic       dv_in;
  logic [7:0] px_in;
  logic [9:0] peak_col;
  logic [9:0] peak_row;
  logic [7:0] peak_val;
  logic       peak_found;
  logic       peak_valid;

  int n_checks = 0;
  int n_errors = 0;
  string phase = "init";

  // Reference model: pixels of the open line kept in a queue, reported on each line edge
  bit m_prev_h;
  bit m_prev_v;
  bit m_in_frame;
  int m_row;
  int m_line[$];
  int e_col, e_row, e_val, e_found, e_valid;

  logic [2:0] rf;
  logic       rd;
  logic [7:0] rp;

  laser_peak_detect #(
    .IMG_WIDTH(W),
    .THRESHOLD(8'(TH))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fvh_in    (fvh_in),
    .dv_in     (dv_in),
    .px_in     (px_in),
    .peak_col  (peak_col),
    .peak_row  (peak_row),
    .peak_val  (peak_val),
    .peak_found(peak_found),
    .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({phase, ".", tag, ".valid"}, peak_valid, e_valid);
    check({phase, ".", tag, ".col"},   peak_col,   e_col);
    check({phase, ".", tag, ".row"},   peak_row,   e_row);
    check({phase, ".", tag, ".val"},   peak_val,   e_val);
    check({phase, ".", tag, ".found"}, peak_found, e_found);
  endtask

  task automatic model_step(input logic [2:0] f, input logic d, input logic [7:0] p);
    bit vr, hr;
    int mx, mc;
    vr = f[1] && !m_prev_v;
    hr = f[0] && !m_prev_h;
    m_prev_v = f[1];
    m_prev_h = f[0];
    e_valid = 0;
    if (vr) begin
      m_in_frame = 1;
      m_row = 0;
      m_line.delete();
    end else if (m_in_frame) begin
      if (hr) begin
        mx = 0;
        mc = 0;
        foreach (m_line[i]) begin
          if (m_line[i] > mx) begin
            mx = m_line[i];
            mc = (i > W - 1) ? W - 1 : i;
          end
        end
        e_val   = mx;
        e_col   = mc;
        e_found = (mx >= TH) ? 1 : 0;
        e_row   = (m_row > 1023) ? 1023 : m_row;
        e_valid = 1;
        m_row++;
        m_line.delete();
      end
      if (d) m_line.push_back(int'(p));
    end
  endtask

  task automatic step(input logic [2:0] f, input logic d, input logic [7:0] p);
    fvh_in = f;
    dv_in  = d;
    px_in  = p;
    model_step(f, d, p);
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic px(input logic [7:0] p);
    step(3'b000, 1'b1, p);
  endtask

  task automatic v_edge();
    step(3'b010, 1'b0, 8'd0);
  endtask

  task automatic h_edge(input logic d, input logic [7:0] p);
    step(3'b001, d, p);
  endtask

  // Called #1 after a rising edge; fvh is held at hold_fvh while reset is high
  task automatic pulse_reset(input int cycles, input logic [2:0] hold_fvh);
    reset  = 1'b1;
    fvh_in = hold_fvh;
    dv_in  = 1'b0;
    px_in  = 8'd0;
    m_prev_h = 0; m_prev_v = 0; m_in_frame = 0; m_row = 0;
    m_line.delete();
    e_col = 0; e_row = 0; e_val = 0; e_found = 0; e_valid = 0;
    #1;
    check_outputs("rst");
    repeat (cycles) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; fvh_in = 3'b000; dv_in = 1'b0; px_in = 8'd0;
    #1;
    phase = "reset";
    pulse_reset(3, 3'b000);
    step(3'b001, 1'b1, 8'd99);           // line edge before any frame: ignored
    check("reset.no_strobe_wait", peak_valid, 1'b0);

    phase = "r031";
    v_edge();
    for (int i = 0; i < 10; i++) px((i == 6) ? 8'd200 : 8'd20);
    h_edge(1'b0, 8'd0);
    check("r031.valid", peak_valid, 1'b1);
    check("r031.col",   peak_col,   10'd6);
    check("r031.val",   peak_val,   8'd200);
    check("r031.row",   peak_row,   10'd0);
    check("r031.found", peak_found, 1'b1);
    step(3'b000, 1'b0, 8'd0);
    check("r031.strobe_1cyc", peak_valid, 1'b0);
    check("r031.hold_col",    peak_col,   10'd6);

    phase = "r032";
    v_edge();
    px(8'd10); px(8'd20); px(8'd30); px(8'd63); px(8'd5);
    h_edge(1'b0, 8'd0);
    check("r032.val63",   peak_val,   8'd63);
    check("r032.found63", peak_found, 1'b0);
    check("r032.col63",   peak_col,   10'd3);
    px(8'd1); px(8'd64); px(8'd3);
    h_edge(1'b0, 8'd0);
    check("r032.found64", peak_found, 1'b1);
    check("r032.row1",    peak_row,   10'd1);

    phase = "r033";
    for (int i = 0; i < 10; i++) px((i == 2 || i == 8) ? 8'd150 : 8'd7);
    h_edge(1'b0, 8'd0);
    check("r033.tie_col", peak_col, 10'd2);
    check("r033.row",     peak_row, 10'd2);

    phase = "r034";
    px(8'd3); px(8'd10); px(8'd4);
    h_edge(1'b1, 8'd255);
    check("r034.prev_val", peak_val, 8'd10);
    px(8'd100); px(8'd255); px(8'd7);
    h_edge(1'b0, 8'd0);
    check("r034.new_col", peak_col, 10'd0);
    check("r034.new_val", peak_val, 8'd255);

    phase = "empty";
    step(3'b000, 1'b0, 8'd0); step(3'b000, 1'b0, 8'd0);
    h_edge(1'b0, 8'd0);
    check("empty.valid", peak_valid, 1'b1);
    check("empty.val",   peak_val,   8'd0);
    check("empty.col",   peak_col,   10'd0);
    check("empty.found", peak_found, 1'b0);

    phase = "vh_same";
    px(8'd90); px(8'd91);
    step(3'b011, 1'b0, 8'd0);
    check("vh_same.no_strobe", peak_valid, 1'b0);
    px(8'd70);
    h_edge(1'b0, 8'd0);
    check("vh_same.row0", peak_row, 10'd0);
    check("vh_same.val",  peak_val, 8'd70);

    phase = "r035";
    v_edge();
    for (int i = 0; i < 400; i++) px(8'($urandom_range(0, 100)));
    pulse_reset(2, 3'b000);
    px(8'd50);
    h_edge(1'b0, 8'd0);
    check("r035.no_strobe", peak_valid, 1'b0);
    px(8'd60);
    h_edge(1'b0, 8'd0);
    check("r035.no_strobe2", peak_valid, 1'b0);
    v_edge();
    for (int i = 0; i < 5; i++) px(8'(30 + i));
    h_edge(1'b0, 8'd0);
    check("r035.valid", peak_valid, 1'b1);
    check("r035.row0",  peak_row,   10'd0);

    phase = "r030";
    pulse_reset(2, 3'b010);
    step(3'b010, 1'b0, 8'd0);            // v already high at release counts as an edge
    px(8'd77);
    h_edge(1'b0, 8'd0);
    check("r030.valid", peak_valid, 1'b1);
    check("r030.val",   peak_val,   8'd77);

    phase = "r036";
    v_edge();
    for (int i = 0; i < 1000; i++) px((i == 999) ? 8'd255 : 8'(i % 200));
    h_edge(1'b0, 8'd0);
    check("r036.sat_col", peak_col, 10'd858);
    check("r036.val",     peak_val, 8'd255);

    phase = "rowsat";
    v_edge();
    for (int i = 0; i < 1030; i++) begin
      h_edge(1'($urandom_range(0, 1)), 8'($urandom));
      step(3'b000, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    check("rowsat.row", peak_row, 10'd1023);

    phase = "random";
    rf = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) rf[0] = ~rf[0];
      if ($urandom_range(0, 299) == 0) rf[1] = ~rf[1];
      rf[2] = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) != 0);
      rp = 8'($urandom);
      if (rf[1] && !m_prev_v) rd = 1'b0;
      step(rf, rd, rp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
